// File: rtl/bp_profiler_pkg.sv
// Shared profiler types for the stall-histogram reader.
// Contents:
//   bp_stall_reason_e / bp_stall_reason_s : encoded and one-hot stall reasons
//   stall_hist_instret_idx_gp              : read address of the instret counter
//   stall_hist_cycle_idx_gp                : read address of the cycle counter
//   bp_stall_hist_state_e                  : read-port FSM states
package bp_profiler_pkg;

    localparam int bp_num_stall_reasons_gp = 32;

    typedef enum logic [4:0] {
        e_stall_none              = 5'd0,
        e_stall_ifetch            = 5'd1,
        e_stall_icache_miss       = 5'd2,
        e_stall_dcache_miss       = 5'd3,
        e_stall_branch_mispredict = 5'd4,
        e_stall_long_op           = 5'd5,
        e_stall_fence             = 5'd6,
        e_stall_csr               = 5'd7,
        e_stall_exception         = 5'd8
    } bp_stall_reason_e;

    typedef struct packed {
        logic [bp_num_stall_reasons_gp-1:0] reasons;
    } bp_stall_reason_s;

    // The two extra counters sit directly above the reason counters.
    localparam int stall_hist_instret_idx_gp = bp_num_stall_reasons_gp;
    localparam int stall_hist_cycle_idx_gp   = bp_num_stall_reasons_gp + 1;

    typedef enum logic {
        e_hist_idle,
        e_hist_resp
    } bp_stall_hist_state_e;

endpackage

// File: rtl/bp_stall_hist_reader_if.sv
// Host read port of the stall-histogram reader.
// Signal names are from the reader's point of view (_i into it, _o out).
//   rd_v_i / rd_ready_o            : request handshake
//   rd_addr_i, rd_clear_i          : counter index and clear-on-read
//   rd_v_o / rd_data_o / rd_yumi_i : response, consumed by yumi
// Modports: slave = the reader, master = the host CSR shell.
interface bp_stall_hist_reader_if #(
    parameter int cnt_width_p  = 32,
    parameter int addr_width_p = 6
);
    logic                    rd_v_i;
    logic                    rd_ready_o;
    logic [addr_width_p-1:0] rd_addr_i;
    logic                    rd_clear_i;
    logic                    rd_v_o;
    logic [cnt_width_p-1:0]  rd_data_o;
    logic                    rd_yumi_i;

    modport slave (
        input  rd_v_i, rd_addr_i, rd_clear_i, rd_yumi_i,
        output rd_ready_o, rd_v_o, rd_data_o
    );

    modport master (
        output rd_v_i, rd_addr_i, rd_clear_i, rd_yumi_i,
        input  rd_ready_o, rd_v_o, rd_data_o
    );
endinterface

// File: rtl/bp_stall_hist_counter.sv
// One histogram counter.
// Ports: clk_i, reset_li (async active-low), up_i (increment this cycle),
//        clear_i (restart from zero this cycle), count_o (current value).
// Optional macro BP_STALL_HIST_SATURATE_EN: stick at all-ones instead of wrapping.
module bp_stall_hist_counter #(
    parameter int cnt_width_p = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_li,
    input  logic                   up_i,
    input  logic                   clear_i,
    output logic [cnt_width_p-1:0] count_o
);
    logic [cnt_width_p-1:0] r_count;
    logic [cnt_width_p-1:0] w_base;
    logic [cnt_width_p-1:0] w_next;

    // Clear replaces the old value before the increment is added, so an
    // event landing in the clearing cycle still counts.
    always_comb begin
        w_base = clear_i ? '0 : r_count;
`ifdef BP_STALL_HIST_SATURATE_EN
        w_next = (up_i && !(&w_base)) ? w_base + 1'b1 : w_base;
`else
        w_next = up_i ? w_base + 1'b1 : w_base;
`endif
    end

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) r_count <= '0;
        else           r_count <= w_next;
    end

    assign count_o = r_count;
endmodule

// File: rtl/bp_stall_hist_reader.sv
// Stall-reason histogram with a single-outstanding host read port.
// Ports: clk_i, reset_li (async active-low), freeze_i, instret_i, stall_v_i,
//        stall_reason_i, rd_if (bp_stall_hist_reader_if.slave).
// Counter map: 0..num_reasons_p-1 reasons, num_reasons_p instret,
//              num_reasons_p+1 cycles. Other addresses read 0.
// Optional macro BP_STALL_HIST_SATURATE_EN: counters saturate instead of wrap.
module bp_stall_hist_reader
    import bp_profiler_pkg::*;
#(
    parameter int num_reasons_p    = 32,
    parameter int cnt_width_p      = 32,
    parameter int lg_num_reasons_p = $clog2(num_reasons_p),
    parameter int addr_width_p     = $clog2(num_reasons_p + 2)
) (
    input  logic                        clk_i,
    input  logic                        reset_li,
    input  logic                        freeze_i,
    input  logic                        instret_i,
    input  logic                        stall_v_i,
    input  logic [lg_num_reasons_p-1:0] stall_reason_i,
    bp_stall_hist_reader_if.slave       rd_if
);
    localparam int num_ctr_lp     = num_reasons_p + 2;
    localparam int instret_idx_lp = num_reasons_p;
    localparam int cycle_idx_lp   = num_reasons_p + 1;

    bp_stall_hist_state_e    r_state, w_next_state;
    logic [cnt_width_p-1:0]  r_data;
    logic [num_ctr_lp-1:0]   w_up;
    logic [num_ctr_lp-1:0]   w_clr;
    logic [cnt_width_p-1:0]  w_counts [num_ctr_lp];
    logic [cnt_width_p-1:0]  w_rd_val;
    logic [addr_width_p-1:0] w_addr;
    logic [addr_width_p-1:0] w_reason_idx;
    logic                    w_addr_ok;
    logic                    w_accept;

    assign w_addr       = rd_if.rd_addr_i;
    assign w_reason_idx = addr_width_p'(stall_reason_i);
    assign w_addr_ok    = int'(w_addr) < num_ctr_lp;
    assign w_accept     = (r_state == e_hist_idle) && rd_if.rd_v_i;

    // Increment decode: cycles always tick when not frozen; retire wins
    // over a stall so at most one of instret/reason moves per cycle.
    always_comb begin
        w_up = '0;
        if (!freeze_i) begin
            w_up[cycle_idx_lp] = 1'b1;
            if (instret_i)
                w_up[instret_idx_lp] = 1'b1;
            else if (stall_v_i && (int'(stall_reason_i) < num_reasons_p))
                w_up[w_reason_idx] = 1'b1;
        end
    end

    // Clear-on-read only touches a real counter on an accepted request.
    always_comb begin
        w_clr = '0;
        if (w_accept && rd_if.rd_clear_i && w_addr_ok)
            w_clr[w_addr] = 1'b1;
    end

    for (genvar g = 0; g < num_ctr_lp; g++) begin : g_cnt
        bp_stall_hist_counter #(.cnt_width_p(cnt_width_p)) u_cnt (
            .clk_i   (clk_i),
            .reset_li(reset_li),
            .up_i    (w_up[g]),
            .clear_i (w_clr[g]),
            .count_o (w_counts[g])
        );
    end

    // Read mux sees the pre-increment, pre-clear counter value.
    always_comb begin
        w_rd_val = '0;
        if (w_addr_ok)
            w_rd_val = w_counts[w_addr];
    end

    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) r_state <= e_hist_idle;
        else           r_state <= w_next_state;
    end

    // Read FSM: one request accepted in IDLE, held in RESP until yumi.
    always_comb begin
        w_next_state     = r_state;
        rd_if.rd_ready_o = 1'b0;
        rd_if.rd_v_o     = 1'b0;
        case (r_state)
            e_hist_idle: begin
                rd_if.rd_ready_o = 1'b1;
                if (rd_if.rd_v_i) w_next_state = e_hist_resp;
            end
            e_hist_resp: begin
                rd_if.rd_v_o = 1'b1;
                if (rd_if.rd_yumi_i) w_next_state = e_hist_idle;
            end
            default: w_next_state = e_hist_idle;
        endcase
    end

    // Response register only loads on accept so data stays stable in RESP.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li)     r_data <= '0;
        else if (w_accept) r_data <= w_rd_val;
    end

    assign rd_if.rd_data_o = r_data;
endmodule

// File: tb/tb_bp_stall_hist_reader.sv
// Self-checking bench for bp_stall_hist_reader: directed vector table,
// hand-written corner sequences, and randomized traffic against a
// behavioural counter-array model. A 4-bit instance covers wrap/saturate.
module tb_bp_stall_hist_reader;
    import bp_profiler_pkg::*;

    localparam int NR = 32;
    localparam int CW = 32;
    localparam int LG = $clog2(NR);
    localparam int AW = $clog2(NR + 2);
    localparam int IRX = stall_hist_instret_idx_gp;
    localparam int CYX = stall_hist_cycle_idx_gp;

    logic clk_i = 1'b0;
    logic reset_li = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          freeze, instret, stallV;
    logic [LG-1:0] reason;
    logic          smallStallV;

    bp_stall_hist_reader_if #(.cnt_width_p(CW), .addr_width_p(AW)) rdIf ();
    bp_stall_hist_reader_if #(.cnt_width_p(4),  .addr_width_p(AW)) smallIf ();

    bp_stall_hist_reader #(.num_reasons_p(NR), .cnt_width_p(CW)) dut (
        .clk_i(clk_i), .reset_li(reset_li), .freeze_i(freeze), .instret_i(instret),
        .stall_v_i(stallV), .stall_reason_i(reason), .rd_if(rdIf)
    );

    bp_stall_hist_reader #(.num_reasons_p(NR), .cnt_width_p(4)) dutSmall (
        .clk_i(clk_i), .reset_li(reset_li), .freeze_i(1'b0), .instret_i(1'b0),
        .stall_v_i(smallStallV), .stall_reason_i(5'd0), .rd_if(smallIf)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Behavioural model: counter array, pending flag, last response.
    logic [CW-1:0] mCnt [NR+2];
    logic          mPend;
    logic [CW-1:0] mResp;

    typedef struct {
        logic          stallV;
        logic [LG-1:0] reason;
        logic          instret;
        logic          rdV;
        logic [AW-1:0] addr;
        logic          clear;
        logic          yumi;
        logic          expV;
        logic [CW-1:0] expData;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [CW-1:0] bump(input logic [CW-1:0] v);
`ifdef BP_STALL_HIST_SATURATE_EN
        return (v == {CW{1'b1}}) ? v : v + 1;
`else
        return v + 1;
`endif
    endfunction

    task automatic checkVal(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic modelReset();
        for (int i = 0; i < NR + 2; i++) mCnt[i] = '0;
        mPend = 1'b0;
        mResp = '0;
    endtask

    // Drive one cycle of main-DUT inputs, advance the model, step the clock.
    task automatic applyStimulus(input logic f, input logic ins, input logic sv,
                                 input logic [LG-1:0] rs, input logic rv,
                                 input logic [AW-1:0] ad, input logic cl, input logic yu);
        logic accept;
        freeze = f; instret = ins; stallV = sv; reason = rs;
        rdIf.rd_v_i = rv; rdIf.rd_addr_i = ad; rdIf.rd_clear_i = cl; rdIf.rd_yumi_i = yu;
        accept = !mPend && rv;
        if (accept) mResp = (int'(ad) < NR + 2) ? mCnt[ad] : '0;
        for (int i = 0; i < NR + 2; i++) begin
            logic [CW-1:0] base;
            logic up;
            base = (accept && cl && int'(ad) == i) ? '0 : mCnt[i];
            up = !f && ((i == CYX) || (i == IRX && ins) ||
                        (i < NR && !ins && sv && int'(rs) == i));
            mCnt[i] = up ? bump(base) : base;
        end
        if (accept) mPend = 1'b1;
        else if (mPend && yu) mPend = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".rdV"},     32'(rdIf.rd_v_o),     32'(mPend));
        checkVal({tag, ".rdReady"}, 32'(rdIf.rd_ready_o), 32'(!mPend));
        checkVal({tag, ".rdData"},  rdIf.rd_data_o,       mResp);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, '0, 0, '0, 0, 0);
    endtask

    // Accept a read, check its data, then consume it.
    task automatic readCheck(input string name, input logic [AW-1:0] ad,
                             input logic cl, input logic sv, input logic [LG-1:0] rs,
                             input logic [CW-1:0] exp);
        applyStimulus(0, 0, sv, rs, 1, ad, cl, 0);
        checkVal(name, rdIf.rd_data_o, exp);
        applyStimulus(0, 0, 0, '0, 0, '0, 0, 1);
    endtask

    task automatic addVec(input logic sv, input logic [LG-1:0] rs, input logic ins,
                          input logic rv, input logic [AW-1:0] ad, input logic cl,
                          input logic yu, input logic ev, input logic [CW-1:0] ed);
        vec_t v;
        v.stallV = sv; v.reason = rs; v.instret = ins; v.rdV = rv; v.addr = ad;
        v.clear = cl; v.yumi = yu; v.expV = ev; v.expData = ed;
        vecs.push_back(v);
    endtask

    initial begin
        logic [CW-1:0] snap;
        logic [CW-1:0] snap2;
        logic [CW-1:0] smallExp;

        freeze = 0; instret = 0; stallV = 0; reason = '0; smallStallV = 0;
        rdIf.rd_v_i = 0; rdIf.rd_addr_i = '0; rdIf.rd_clear_i = 0; rdIf.rd_yumi_i = 0;
        smallIf.rd_v_i = 0; smallIf.rd_addr_i = '0; smallIf.rd_clear_i = 0; smallIf.rd_yumi_i = 0;
        modelReset();

        // Reset state
        #2;
        checkVal("reset.rdV",     32'(rdIf.rd_v_o),     0);
        checkVal("reset.rdReady", 32'(rdIf.rd_ready_o), 1);
        checkVal("reset.rdData",  rdIf.rd_data_o,       0);
        repeat (3) @(posedge clk_i);
        #1 reset_li = 1'b1;

        // Directed vector table; row index = cycles elapsed since reset.
        for (int i = 0; i < 10; i++) addVec(1, 5'd3, 0, 0, '0, 0, 0, 0, 0);
        addVec(0, 0, 0, 1, 6'd3,  0, 0, 1, 10);
        addVec(0, 0, 0, 0, '0,    0, 1, 0, 10);
        addVec(0, 0, 0, 1, 6'(CYX), 0, 0, 1, 12);
        addVec(0, 0, 0, 0, '0,    0, 1, 0, 12);
        for (int i = 0; i < 4; i++) addVec(1, 5'd5, 1, 0, '0, 0, 0, 0, 12);
        addVec(0, 0, 0, 1, 6'(IRX), 0, 0, 1, 4);
        addVec(0, 0, 0, 0, '0,    0, 1, 0, 4);
        addVec(0, 0, 0, 1, 6'd5,  0, 0, 1, 0);
        addVec(0, 0, 0, 0, '0,    0, 1, 0, 0);
        addVec(0, 0, 0, 1, 6'd3,  0, 0, 1, 10);
        addVec(0, 0, 0, 0, '0,    0, 1, 0, 10);
        addVec(0, 0, 0, 1, 6'd40, 1, 0, 1, 0);
        addVec(0, 0, 0, 0, '0,    0, 1, 0, 0);
        addVec(0, 0, 0, 1, 6'(CYX), 1, 0, 1, 26);
        addVec(0, 0, 0, 0, '0,    0, 1, 0, 26);
        addVec(0, 0, 0, 1, 6'(CYX), 0, 0, 1, 2);
        addVec(0, 0, 0, 0, '0,    0, 1, 0, 2);

        foreach (vecs[i]) begin
            applyStimulus(0, vecs[i].instret, vecs[i].stallV, vecs[i].reason,
                          vecs[i].rdV, vecs[i].addr, vecs[i].clear, vecs[i].yumi);
            checkVal($sformatf("vec%0d.rdV", i),     32'(rdIf.rd_v_o),     32'(vecs[i].expV));
            checkVal($sformatf("vec%0d.rdReady", i), 32'(rdIf.rd_ready_o), 32'(!vecs[i].expV));
            checkVal($sformatf("vec%0d.rdData", i),  rdIf.rd_data_o,       vecs[i].expData);
        end

        // Clear-on-read with a same-cycle increment on counter[2].
        repeat (7) applyStimulus(0, 0, 1, 5'd2, 0, '0, 0, 0);
        readCheck("clearRead.pre", 6'd2, 1, 1, 5'd2, 7);
        readCheck("clearRead.post", 6'd2, 0, 0, '0, 1);

        // Freeze: counters hold, reads still work.
        snap = mCnt[CYX];
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, i[0], 1, 5'd2, (i == 5 || i == 10),
                          (i == 5) ? 6'd2 : 6'(CYX), 0, (i == 6 || i == 11));
            if (i == 5)  checkVal("freeze.readCnt2", rdIf.rd_data_o, 1);
            if (i == 10) checkVal("freeze.readCycles", rdIf.rd_data_o, snap);
        end
        readCheck("freeze.after", 6'd2, 0, 0, '0, 1);

        // rd_v_i held high in RESP: no second accept, data stable.
        snap = mCnt[CYX];
        applyStimulus(0, 0, 0, '0, 1, 6'(CYX), 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, '0, 1, 6'(CYX), 0, 0);
            checkVal("hold.rdReady", 32'(rdIf.rd_ready_o), 0);
            checkVal("hold.rdData", rdIf.rd_data_o, snap);
        end
        applyStimulus(0, 0, 0, '0, 1, 6'(CYX), 0, 1);
        checkVal("hold.yumiV", 32'(rdIf.rd_v_o), 0);
        snap2 = mCnt[CYX];
        applyStimulus(0, 0, 0, '0, 1, 6'(CYX), 0, 0);
        checkVal("hold.reaccept", rdIf.rd_data_o, snap2);
        applyStimulus(0, 0, 0, '0, 0, '0, 0, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) == 0),
                          1'($urandom), 5'($urandom), 1'($urandom),
                          6'($urandom_range(0, 40)), ($urandom_range(0, 3) == 0), 1'($urandom));
            checkOutput("rand");
        end

        // 4-bit instance: wrap (or saturate) and clear of a full counter.
        applyStimulus(0, 0, 0, '0, 0, '0, 0, 1);
        smallIf.rd_yumi_i = 0; smallIf.rd_v_i = 0;
        for (int i = 0; i < 15; i++) begin
            smallStallV = 1;
            idle();
        end
        smallStallV = 0;
        smallIf.rd_v_i = 1; smallIf.rd_addr_i = 6'd0;
        idle();
        checkVal("small.full", 32'(smallIf.rd_data_o), 15);
        smallIf.rd_v_i = 0; smallIf.rd_yumi_i = 1; smallStallV = 1;
        idle();
        smallIf.rd_yumi_i = 0; smallStallV = 0; smallIf.rd_v_i = 1;
        idle();
`ifdef BP_STALL_HIST_SATURATE_EN
        smallExp = 15;
`else
        smallExp = 0;
`endif
        checkVal("small.overflow", 32'(smallIf.rd_data_o), smallExp);
        smallIf.rd_v_i = 0; smallIf.rd_yumi_i = 1;
        idle();
        smallIf.rd_yumi_i = 0; smallIf.rd_v_i = 1; smallIf.rd_clear_i = 1; smallStallV = 1;
        idle();
        checkVal("small.clearRead", 32'(smallIf.rd_data_o), smallExp);
        smallIf.rd_v_i = 0; smallIf.rd_clear_i = 0; smallStallV = 0; smallIf.rd_yumi_i = 1;
        idle();
        smallIf.rd_yumi_i = 0; smallIf.rd_v_i = 1;
        idle();
        checkVal("small.afterClear", 32'(smallIf.rd_data_o), 1);
        smallIf.rd_v_i = 0; smallIf.rd_yumi_i = 1;
        idle();
        smallIf.rd_yumi_i = 0;

        // Reset while a response is pending.
        repeat (3) applyStimulus(0, 0, 1, 5'd4, 0, '0, 0, 0);
        applyStimulus(0, 0, 0, '0, 1, 6'd4, 0, 0);
        checkVal("midReset.preV", 32'(rdIf.rd_v_o), 1);
        reset_li = 1'b0;
        modelReset();
        #1;
        checkVal("midReset.rdV",     32'(rdIf.rd_v_o),     0);
        checkVal("midReset.rdReady", 32'(rdIf.rd_ready_o), 1);
        checkVal("midReset.rdData",  rdIf.rd_data_o,       0);
        rdIf.rd_v_i = 0;
        @(posedge clk_i);
        #1 reset_li = 1'b1;
        readCheck("midReset.cycles", 6'(CYX), 0, 0, '0, 0);
        readCheck("midReset.cnt4",   6'd4,   0, 0, '0, 0);
        readCheck("midReset.instret", 6'(IRX), 0, 0, '0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
